// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset control unit.
package mc_ctrl_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    // R-type funct codes
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b01110;
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_SLT = 5'b01111;

    // Next-PC select
    localparam logic [1:0] PCS_PC4 = 2'b00;
    localparam logic [1:0] PCS_JMP = 2'b01;
    localparam logic [1:0] PCS_BR  = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_ALUWB,
        S_BRANCH,
        S_JUMP
    } state_t;

endpackage

// File: rtl/mc_ctrl_alu_dec.sv
// Funct-to-ALU-op decoder; legal flags the five supported R-type functs.
module alu_dec
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] funct,
    output logic [4:0] alu_op,
    output logic       legal
);

    // Unknown functs fall back to ADD with legal low.
    always_comb begin
        alu_op = ALU_ADD;
        legal  = 1'b1;
        case (funct)
            FN_ADD:  alu_op = ALU_ADD;
            FN_SUB:  alu_op = ALU_SUB;
            FN_AND:  alu_op = ALU_AND;
            FN_OR:   alu_op = ALU_OR;
            FN_SLT:  alu_op = ALU_SLT;
            default: legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM: fetch, decode, execute, memory, writeback.
// Outputs are purely combinational from state and the listed inputs.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mem_rdy,
    input  logic       eq,
    input  logic [5:0] ir31_26,
    input  logic [5:0] ir5_0,
    output logic       ir_we,
    output logic       pc_we,
    output logic       mem_s,
    output logic       rf_we,
    output logic       add2_s,
    output logic       rf_wd_s,
    output logic       dm_we,
    output logic       rf_wa_s,
    output logic [4:0] alu_op,
    output logic [1:0] pc_s,
    output logic       illegal
);

    state_t     state, state_nxt;
    logic [4:0] fn_alu_op;
    logic       fn_legal;

    alu_dec u_alu_dec (
        .funct  (ir5_0),
        .alu_op (fn_alu_op),
        .legal  (fn_legal)
    );

    // State register, cleared to FETCH asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Next-state and output decode; reset overrides everything back to defaults.
    always_comb begin
        state_nxt = state;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        mem_s     = 1'b0;
        rf_we     = 1'b0;
        add2_s    = 1'b0;
        rf_wd_s   = 1'b0;
        dm_we     = 1'b0;
        rf_wa_s   = 1'b0;
        alu_op    = ALU_ADD;
        pc_s      = PCS_PC4;
        illegal   = 1'b0;
        case (state)
            S_FETCH: begin
                ir_we = mem_rdy;
                pc_we = mem_rdy;
                if (mem_rdy) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                case (ir31_26)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_ADDI:      state_nxt = S_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_RTYPE: begin
                        if (fn_legal) begin
                            state_nxt = S_EXEC;
                        end else begin
                            illegal   = 1'b1;
                            state_nxt = S_FETCH;
                        end
                    end
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_op    = ALU_ADD;
                add2_s    = 1'b0;
                state_nxt = (ir31_26 == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_s = 1'b1;
                if (mem_rdy) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we     = 1'b1;
                rf_wd_s   = 1'b0;
                rf_wa_s   = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                mem_s = 1'b1;
                dm_we = 1'b1;
                if (mem_rdy) state_nxt = S_FETCH;
            end
            S_EXEC: begin
                if (ir31_26 == OP_RTYPE) begin
                    add2_s = 1'b1;
                    alu_op = fn_alu_op;
                end
                state_nxt = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we     = 1'b1;
                rf_wd_s   = 1'b1;
                rf_wa_s   = (ir31_26 == OP_ADDI);
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                add2_s    = 1'b1;
                alu_op    = ALU_SUB;
                pc_we     = eq;
                pc_s      = eq ? PCS_BR : PCS_PC4;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pc_we     = 1'b1;
                pc_s      = PCS_JMP;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
        if (!rst_n) begin
            ir_we   = 1'b0;
            pc_we   = 1'b0;
            mem_s   = 1'b0;
            rf_we   = 1'b0;
            add2_s  = 1'b0;
            rf_wd_s = 1'b0;
            dm_we   = 1'b0;
            rf_wa_s = 1'b0;
            alu_op  = ALU_ADD;
            pc_s    = PCS_PC4;
            illegal = 1'b0;
        end
    end

endmodule
